// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin select arbiter.
// Optional grant timeout is enabled by defining RR_ARB_TIMEOUT_EN.
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_e;

  // Width of a counter that must hold 0 .. t-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// Circular priority encoder: first set request at or after ptr, wrapping
// modulo OUTS. Purely combinational.
module rr_pick #(
  parameter int WIDTH = 2,
  parameter int OUTS  = 4
) (
  input  logic [OUTS-1:0]  req,
  input  logic [WIDTH-1:0] ptr,
  output logic             found,
  output logic [WIDTH-1:0] idx
);

  // Two linear passes instead of a modulo rotate: the first only accepts
  // indices at or above ptr, the second takes the lowest index overall,
  // which is exactly the wrapped-around winner when the first pass misses.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < OUTS; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        found = 1'b1;
        idx   = WIDTH'(i);
      end
    end
    for (int unsigned i = 0; i < OUTS; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing a binary select plus enable for a downstream
// decoder. Grants are held until the grantee asserts done; one idle bubble
// separates consecutive grants.
// Define RR_ARB_TIMEOUT_EN to force-release a grant after TIMEOUT cycles.
module rr_sel_arbiter
  import rr_arb_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int OUTS    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OUTS-1:0]  req,
  input  logic             done,
  output logic [WIDTH-1:0] sel,
  output logic             enable,
  output logic             timeout
);

  if (OUTS < 1 || OUTS > (1 << WIDTH)) begin : g_bad_outs
    $fatal(1, "rr_sel_arbiter: OUTS must be in 1 .. 2**WIDTH");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $fatal(1, "rr_sel_arbiter: TIMEOUT must be at least 1");
  end

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(OUTS - 1);

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
`endif

  arb_state_e       state_q;
  logic [WIDTH-1:0] sel_q;
  logic             enable_q;
  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;
  logic             found;
  logic [WIDTH-1:0] pick_idx;

  rr_pick #(
    .WIDTH(WIDTH),
    .OUTS (OUTS)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .found(found),
    .idx  (pick_idx)
  );

  // Pointer for the next search: one past the current grantee, wrapping at OUTS.
  always_comb begin
    ptr_d = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
  end

  // Arbitration FSM with registered sel/enable/timeout and optional hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      enable_q  <= 1'b0;
      ptr_q     <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            sel_q    <= pick_idx;
            enable_q <= 1'b1;
            state_q  <= ST_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (done) begin
            enable_q <= 1'b0;
            ptr_q    <= ptr_d;
            state_q  <= ST_IDLE;
          end
`ifdef RR_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            enable_q  <= 1'b0;
            ptr_q     <= ptr_d;
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q  <= ST_IDLE;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel    = sel_q;
  assign enable = enable_q;
`ifdef RR_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter (WIDTH=2, OUTS=4, TIMEOUT=4).
// Honours RR_ARB_TIMEOUT_EN the same way as the design.
module tb_rr_sel_arbiter;

  localparam int W  = 2;
  localparam int N  = 4;
  localparam int TO = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [W-1:0] sel;
  logic         enable;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant, where the next search starts,
  // and how many cycles enable has been high.
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_held;
  bit m_to;

  rr_sel_arbiter #(
    .WIDTH  (W),
    .OUTS   (N),
    .TIMEOUT(TO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .sel    (sel),
    .enable (enable),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    m_held = 0;
    m_to   = 1'b0;
  endtask

  // One clock edge of the arbitration rules, applied to the pre-edge inputs.
  task automatic model_edge(input logic [N-1:0] r, input logic d);
    bit hit;
    m_to = 1'b0;
    if (!m_busy) begin
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!hit && r[j]) begin
          hit    = 1'b1;
          m_sel  = j;
          m_busy = 1'b1;
          m_held = 1;
        end
      end
    end else if (d) begin
      m_busy = 1'b0;
      m_ptr  = (m_sel + 1) % N;
    end else if (TO_EN && m_held == TO) begin
      m_busy = 1'b0;
      m_ptr  = (m_sel + 1) % N;
      m_to   = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
    chk({tag, ".enable"}, 32'(enable), 32'(m_busy));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  // Drive at the falling edge, step model on the rising edge, check 1 later.
  task automatic cyc(input string tag, input logic [N-1:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  initial begin
    int held;
    int to_seen;

    // 1. Reset with all requests asserted, before any clock edge.
    model_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    #3;
    check_outputs("reset");
    @(negedge clk);
    check_outputs("reset_held");
    rst_n = 1'b1;
    req   = 4'b0000;
    cyc("idle_noreq", 4'b0000, 1'b0);
    cyc("idle_noreq2", 4'b0000, 1'b0);

    // 2. Single requester, release, pointer moves past it.
    cyc("grant2", 4'b0100, 1'b0);
    chk("grant2_sel_const", 32'(sel), 32'd2);
    cyc("grant2_reqdrop", 4'b0000, 1'b0);
    cyc("release2", 4'b0000, 1'b1);
    chk("release2_en_const", 32'(enable), 32'd0);
    cyc("from3", 4'b1111, 1'b0);
    chk("from3_sel_const", 32'(sel), 32'd3);
    cyc("release3", 4'b1111, 1'b1);

    // 3. All requesting: 0,1,2,3,0 with a bubble between grants.
    for (int g = 0; g < 5; g++) begin
      cyc("rr_grant", 4'b1111, 1'b0);
      chk("rr_seq", 32'(sel), 32'(g % N));
      cyc("rr_release", 4'b1111, 1'b1);
      chk("rr_bubble", 32'(enable), 32'd0);
    end

    // Ignored inputs in IDLE: done alone, then done with req on one edge.
    cyc("idle_done", 4'b0000, 1'b1);
    cyc("idle_done_req", 4'b0100, 1'b1);
    cyc("release_b", 4'b0000, 1'b1);

    // 4. Wrap: after granting 2, req=0011 gives 0 then 1.
    cyc("wrap_grant0", 4'b0011, 1'b0);
    chk("wrap_sel0", 32'(sel), 32'd0);
    cyc("wrap_rel0", 4'b0011, 1'b1);
    cyc("wrap_grant1", 4'b0011, 1'b0);
    chk("wrap_sel1", 32'(sel), 32'd1);
    cyc("wrap_rel1", 4'b0000, 1'b1);

    // 5. Reset between edges while granting index 2.
    cyc("pre_rst_grant", 4'b1111, 1'b0);
    chk("pre_rst_sel", 32'(sel), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst_grant", 4'b1111, 1'b0);
    chk("post_rst_sel", 32'(sel), 32'd0);
    cyc("post_rst_rel", 4'b0000, 1'b1);

    // done on the last allowed hold cycle is a normal release.
    cyc("edge_grant", 4'b0010, 1'b0);
    for (int i = 0; i < TO - 1; i++) cyc("edge_hold", 4'b0000, 1'b0);
    cyc("edge_done", 4'b0000, 1'b1);

    // 6. Hold with done low; bounded at 30 cycles.
    cyc("to_grant", 4'b0001, 1'b0);
    held    = 1;
    to_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc("to_hold", 4'b0000, 1'b0);
      if (timeout === 1'b1) to_seen++;
      if (enable !== 1'b1) break;
      held++;
    end
    if (TO_EN) begin
      chk("to_hold_len", 32'(held), 32'(TO));
      chk("to_pulses", 32'(to_seen), 32'd1);
    end else begin
      chk("hold_ge20", 32'(held >= 20), 32'd1);
      chk("no_timeout", 32'(to_seen), 32'd0);
      cyc("hold_release", 4'b0000, 1'b1);
    end
    cyc("after_to", 4'b0000, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      logic d;
      r = N'($urandom_range(0, (1 << N) - 1));
      d = ($urandom_range(0, 3) == 0);
      cyc("rand", r, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
